// File: rtl/mc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// mc_cpu_pkg : opcode, state and control-field encodings for the multicycle CPU
// Revision   : 1.0
// ============================================================================
package mc_cpu_pkg;

    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_ADDIU = 6'b000010;
    localparam logic [5:0] c_OP_AND   = 6'b010000;
    localparam logic [5:0] c_OP_ANDI  = 6'b010001;
    localparam logic [5:0] c_OP_ORI   = 6'b010010;
    localparam logic [5:0] c_OP_XORI  = 6'b010011;
    localparam logic [5:0] c_OP_OR    = 6'b010100;
    localparam logic [5:0] c_OP_SLL   = 6'b011000;
    localparam logic [5:0] c_OP_SLTI  = 6'b100110;
    localparam logic [5:0] c_OP_SLT   = 6'b100111;
    localparam logic [5:0] c_OP_SW    = 6'b110000;
    localparam logic [5:0] c_OP_LW    = 6'b110001;
    localparam logic [5:0] c_OP_BEQ   = 6'b110100;
    localparam logic [5:0] c_OP_BNE   = 6'b110101;
    localparam logic [5:0] c_OP_BLTZ  = 6'b110110;
    localparam logic [5:0] c_OP_J     = 6'b111000;
    localparam logic [5:0] c_OP_JR    = 6'b111001;
    localparam logic [5:0] c_OP_JAL   = 6'b111010;

    // One extra bit beyond the eight pipeline-phase codes gives HALT its own encoding.
    localparam int c_STATE_W = 4;

    typedef enum logic [c_STATE_W-1:0] {
        c_ST_IF     = 4'b0000,
        c_ST_ID     = 4'b0001,
        c_ST_EXE_LS = 4'b0010,
        c_ST_MEM    = 4'b0011,
        c_ST_WB_L   = 4'b0100,
        c_ST_EXE_BR = 4'b0101,
        c_ST_EXE_AL = 4'b0110,
        c_ST_WB_AL  = 4'b0111,
        c_ST_HALT   = 4'b1000
    } state_t;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_SLL  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_AND  = 3'b100;
    localparam logic [2:0] c_ALU_SLTU = 3'b101;
    localparam logic [2:0] c_ALU_SLT  = 3'b110;
    localparam logic [2:0] c_ALU_XOR  = 3'b111;

    localparam logic [1:0] c_PC_NEXT   = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_RS     = 2'b10;
    localparam logic [1:0] c_PC_JUMP   = 2'b11;

    localparam logic [1:0] c_RD_RA = 2'b00;
    localparam logic [1:0] c_RD_RT = 2'b01;
    localparam logic [1:0] c_RD_RD = 2'b10;

    typedef enum logic [2:0] {
        c_CL_UNDEF = 3'd0,
        c_CL_ALU   = 3'd1,
        c_CL_LS    = 3'd2,
        c_CL_BR    = 3'd3,
        c_CL_J     = 3'd4,
        c_CL_JAL   = 3'd5,
        c_CL_JR    = 3'd6
    } op_class_t;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic [2:0] alu_op;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t cl;
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_ADDIU, c_OP_AND, c_OP_ANDI, c_OP_ORI,
            c_OP_XORI, c_OP_OR, c_OP_SLL, c_OP_SLTI, c_OP_SLT: cl = c_CL_ALU;
            c_OP_SW, c_OP_LW:                                   cl = c_CL_LS;
            c_OP_BEQ, c_OP_BNE, c_OP_BLTZ:                      cl = c_CL_BR;
            c_OP_J:                                             cl = c_CL_J;
            c_OP_JAL:                                           cl = c_CL_JAL;
            c_OP_JR:                                            cl = c_CL_JR;
            default:                                            cl = c_CL_UNDEF;
        endcase
        return cl;
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        logic [2:0] a;
        case (op)
            c_OP_SUB:             a = c_ALU_SUB;
            c_OP_AND, c_OP_ANDI:  a = c_ALU_AND;
            c_OP_OR, c_OP_ORI:    a = c_ALU_OR;
            c_OP_XORI:            a = c_ALU_XOR;
            c_OP_SLL:             a = c_ALU_SLL;
            c_OP_SLT, c_OP_SLTI:  a = c_ALU_SLT;
            default:              a = c_ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == c_OP_ADDIU) || (op == c_OP_ANDI) || (op == c_OP_ORI) ||
               (op == c_OP_XORI)  || (op == c_OP_SLTI);
    endfunction

    // Arithmetic immediates are signed; logical immediates are zero-extended.
    function automatic logic is_signed_imm(input logic [5:0] op);
        return (op == c_OP_ADDIU) || (op == c_OP_SLTI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// mc_ctrl_decode : combinational control decode of (state, opcode, zero, sign)
// Revision       : 1.0
// ============================================================================
module mc_ctrl_decode
    import mc_cpu_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        sign,
    output ctrl_t       ctrl
);

    ctrl_t     w_ctrl;
    op_class_t w_class;
    logic      w_taken;

    always_comb begin
        w_ctrl  = '0;
        w_class = classify(opcode);
        w_taken = 1'b0;
        case (state)
            c_ST_IF: begin
                w_ctrl.ir_wre     = 1'b1;
                w_ctrl.ins_mem_rw = 1'b1;
            end
            c_ST_ID: begin
                if (opcode != HALT_OP) begin
                    case (w_class)
                        c_CL_J: begin
                            w_ctrl.pc_wre = 1'b1;
                            w_ctrl.pc_src = c_PC_JUMP;
                        end
                        c_CL_JAL: begin
                            w_ctrl.pc_wre       = 1'b1;
                            w_ctrl.pc_src       = c_PC_JUMP;
                            w_ctrl.reg_wre      = 1'b1;
                            w_ctrl.reg_dst      = c_RD_RA;
                            w_ctrl.wr_reg_d_src = 1'b0;
                        end
                        c_CL_JR: begin
                            w_ctrl.pc_wre = 1'b1;
                            w_ctrl.pc_src = c_PC_RS;
                        end
                        c_CL_UNDEF: begin
                            w_ctrl.pc_wre = 1'b1;
                            w_ctrl.pc_src = c_PC_NEXT;
                        end
                        default: ;
                    endcase
                end
            end
            c_ST_EXE_AL: begin
                w_ctrl.alu_op    = alu_op_of(opcode);
                w_ctrl.alu_src_a = (opcode == c_OP_SLL);
                w_ctrl.alu_src_b = is_imm_op(opcode);
                w_ctrl.ext_sel   = is_signed_imm(opcode);
            end
            c_ST_WB_AL: begin
                w_ctrl.reg_wre      = 1'b1;
                w_ctrl.wr_reg_d_src = 1'b1;
                w_ctrl.reg_dst      = is_imm_op(opcode) ? c_RD_RT : c_RD_RD;
                w_ctrl.pc_wre       = 1'b1;
            end
            c_ST_EXE_BR: begin
                case (opcode)
                    c_OP_BEQ:  w_taken = zero;
                    c_OP_BNE:  w_taken = ~zero;
                    c_OP_BLTZ: w_taken = sign;
                    default:   w_taken = 1'b0;
                endcase
                w_ctrl.alu_op  = c_ALU_SUB;
                w_ctrl.ext_sel = 1'b1;
                w_ctrl.pc_wre  = 1'b1;
                w_ctrl.pc_src  = w_taken ? c_PC_BRANCH : c_PC_NEXT;
            end
            c_ST_EXE_LS: begin
                w_ctrl.alu_op    = c_ALU_ADD;
                w_ctrl.alu_src_b = 1'b1;
                w_ctrl.ext_sel   = 1'b1;
            end
            c_ST_MEM: begin
                if (opcode == c_OP_LW) begin
                    w_ctrl.m_rd = 1'b1;
                end else begin
                    w_ctrl.m_wr   = 1'b1;
                    w_ctrl.pc_wre = 1'b1;
                end
            end
            c_ST_WB_L: begin
                w_ctrl.reg_wre      = 1'b1;
                w_ctrl.reg_dst      = c_RD_RT;
                w_ctrl.wr_reg_d_src = 1'b1;
                w_ctrl.db_data_src  = 1'b1;
                w_ctrl.pc_wre       = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// mc_control_unit : multicycle MIPS-subset control FSM (state register + decode)
// Revision        : 1.0
// ============================================================================
module mc_control_unit
    import mc_cpu_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter int         STATE_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             DBDataSrc,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [STATE_W:0] state
);

    state_t r_state;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IF;
        end else begin
            case (r_state)
                c_ST_IF: r_state <= c_ST_ID;
                c_ST_ID: begin
                    if (opcode == HALT_OP) begin
                        r_state <= c_ST_HALT;
                    end else begin
                        case (classify(opcode))
                            c_CL_ALU: r_state <= c_ST_EXE_AL;
                            c_CL_LS:  r_state <= c_ST_EXE_LS;
                            c_CL_BR:  r_state <= c_ST_EXE_BR;
                            default:  r_state <= c_ST_IF;
                        endcase
                    end
                end
                c_ST_EXE_AL: r_state <= c_ST_WB_AL;
                c_ST_WB_AL:  r_state <= c_ST_IF;
                c_ST_EXE_BR: r_state <= c_ST_IF;
                c_ST_EXE_LS: r_state <= c_ST_MEM;
                c_ST_MEM:    r_state <= (opcode == c_OP_LW) ? c_ST_WB_L : c_ST_IF;
                c_ST_WB_L:   r_state <= c_ST_IF;
                c_ST_HALT:   r_state <= c_ST_HALT;
                default:     r_state <= c_ST_IF;
            endcase
        end
    end

    mc_ctrl_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .state  (r_state),
        .opcode (opcode),
        .zero   (zero),
        .sign   (sign),
        .ctrl   (w_dec)
    );

    // Reset silences every output immediately so an abandoned instruction cannot write.
    assign w_ctrl    = rst ? '0 : w_dec;
    assign state     = rst ? '0 : r_state;

    assign PCWre     = w_ctrl.pc_wre;
    assign IRWre     = w_ctrl.ir_wre;
    assign InsMemRW  = w_ctrl.ins_mem_rw;
    assign RegWre    = w_ctrl.reg_wre;
    assign RegDst    = w_ctrl.reg_dst;
    assign WrRegDSrc = w_ctrl.wr_reg_d_src;
    assign DBDataSrc = w_ctrl.db_data_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ExtSel    = w_ctrl.ext_sel;
    assign ALUOp     = w_ctrl.alu_op;
    assign mRD       = w_ctrl.m_rd;
    assign mWR       = w_ctrl.m_wr;
    assign PCSrc     = w_ctrl.pc_src;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// tb_mc_control_unit : directed + random instruction streams vs. behavioural model
// Revision           : 1.0
// ============================================================================
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero, sign;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc;
    logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;

    mc_control_unit #(
        .HALT_OP (6'b111111),
        .STATE_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .sign      (sign),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .DBDataSrc (DBDataSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .PCSrc     (PCSrc),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wre, ir_wre, ins_rd, reg_wre;
        logic [1:0] reg_dst;
        logic       wr_src, db_src, src_a, src_b, ext;
        logic [2:0] alu;
        logic       m_rd, m_wr;
        logic [1:0] pc_src;
    } exp_t;

    typedef struct packed {
        logic [3:0] st;
        exp_t       e;
    } step_t;

    wire exp_t w_obs = {PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, DBDataSrc,
                        ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, PCSrc};

    localparam logic [3:0] IF = 4'd0, ID = 4'd1, EXE_LS = 4'd2, MEM = 4'd3, WB_L = 4'd4,
                           EXE_BR = 4'd5, EXE_AL = 4'd6, WB_AL = 4'd7;

    int    errors = 0;
    int    checks = 0;
    string mnem [logic [5:0]];
    step_t step_q [$];
    logic [5:0] def_ops [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: expected state/control trace from the ISA description.
    task automatic build(input logic [5:0] op, input logic z, input logic s);
        exp_t  e;
        string m;
        step_q.delete();
        m = mnem.exists(op) ? mnem[op] : "";
        if (op == 6'b111111) m = "halt";
        e = '0; e.ir_wre = 1; e.ins_rd = 1;
        step_q.push_back('{IF, e});
        e = '0;
        case (m)
            "j":    begin e.pc_wre = 1; e.pc_src = 2'b11; step_q.push_back('{ID, e}); end
            "jal":  begin e.pc_wre = 1; e.pc_src = 2'b11; e.reg_wre = 1; e.reg_dst = 2'b00;
                          e.wr_src = 0; step_q.push_back('{ID, e}); end
            "jr":   begin e.pc_wre = 1; e.pc_src = 2'b10; step_q.push_back('{ID, e}); end
            "halt": step_q.push_back('{ID, e});
            "":     begin e.pc_wre = 1; e.pc_src = 2'b00; step_q.push_back('{ID, e}); end
            "beq", "bne", "bltz": begin
                logic taken;
                taken = (m == "beq") ? z : (m == "bne") ? !z : s;
                step_q.push_back('{ID, e});
                e.alu = 3'b001; e.ext = 1; e.pc_wre = 1; e.pc_src = taken ? 2'b01 : 2'b00;
                step_q.push_back('{EXE_BR, e});
            end
            "lw", "sw": begin
                step_q.push_back('{ID, e});
                e.alu = 3'b000; e.src_b = 1; e.ext = 1;
                step_q.push_back('{EXE_LS, e});
                e = '0;
                if (m == "lw") begin
                    e.m_rd = 1;
                    step_q.push_back('{MEM, e});
                    e = '0; e.reg_wre = 1; e.reg_dst = 2'b01; e.wr_src = 1; e.db_src = 1; e.pc_wre = 1;
                    step_q.push_back('{WB_L, e});
                end else begin
                    e.m_wr = 1; e.pc_wre = 1;
                    step_q.push_back('{MEM, e});
                end
            end
            default: begin
                logic imm;
                imm = (m == "addiu") || (m == "andi") || (m == "ori") || (m == "xori") || (m == "slti");
                step_q.push_back('{ID, e});
                case (m)
                    "sub":          e.alu = 3'b001;
                    "sll":          e.alu = 3'b010;
                    "or", "ori":    e.alu = 3'b011;
                    "and", "andi":  e.alu = 3'b100;
                    "slt", "slti":  e.alu = 3'b110;
                    "xori":         e.alu = 3'b111;
                    default:        e.alu = 3'b000;
                endcase
                e.src_a = (m == "sll");
                e.src_b = imm;
                e.ext   = (m == "addiu") || (m == "slti");
                step_q.push_back('{EXE_AL, e});
                e = '0; e.reg_wre = 1; e.wr_src = 1; e.pc_wre = 1; e.reg_dst = imm ? 2'b01 : 2'b10;
                step_q.push_back('{WB_AL, e});
            end
        endcase
    endtask

    // Runs one instruction from IF; on return the DUT has taken the final edge.
    task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
        build(op, z, s);
        opcode = op; zero = z; sign = s;
        #1;
        foreach (step_q[i]) begin
            chk($sformatf("op%b_step%0d_state", op, i), {28'd0, state}, {28'd0, step_q[i].st});
            chk($sformatf("op%b_step%0d_ctrl", op, i), {14'd0, w_obs}, {14'd0, step_q[i].e});
            tick();
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [3:0] halt_st;
        mnem[6'b000000] = "add";  mnem[6'b000001] = "sub";  mnem[6'b000010] = "addiu";
        mnem[6'b010000] = "and";  mnem[6'b010001] = "andi"; mnem[6'b010010] = "ori";
        mnem[6'b010011] = "xori"; mnem[6'b010100] = "or";   mnem[6'b011000] = "sll";
        mnem[6'b100110] = "slti"; mnem[6'b100111] = "slt";  mnem[6'b110000] = "sw";
        mnem[6'b110001] = "lw";   mnem[6'b110100] = "beq";  mnem[6'b110101] = "bne";
        mnem[6'b110110] = "bltz"; mnem[6'b111000] = "j";    mnem[6'b111001] = "jr";
        mnem[6'b111010] = "jal";
        foreach (mnem[k]) def_ops.push_back(k);

        rst = 1'b1; opcode = 6'b110001; zero = 1'b0; sign = 1'b0;
        #1;
        chk("reset_ctrl_t0", {14'd0, w_obs}, 32'd0);
        chk("reset_state_t0", {28'd0, state}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_reset_state", {28'd0, state}, {28'd0, IF});

        // Directed: add, lw, sw, branches, jal, undefined.
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b110001, 1'b0, 1'b0);
        run_instr(6'b110000, 1'b1, 1'b1);
        run_instr(6'b110100, 1'b1, 1'b0);
        run_instr(6'b110100, 1'b0, 1'b0);
        run_instr(6'b110110, 1'b0, 1'b1);
        run_instr(6'b111010, 1'b0, 1'b0);
        run_instr(6'b101010, 1'b0, 1'b0);

        // Reset in the middle of lw, while in MEM.
        opcode = 6'b110001;
        tick(); tick(); tick();
        chk("lw_reached_mem", {28'd0, state}, {28'd0, MEM});
        rst = 1'b1;
        #1;
        chk("midlw_rst_ctrl0", {14'd0, w_obs}, 32'd0);
        chk("midlw_rst_state0", {28'd0, state}, 32'd0);
        tick();
        chk("midlw_rst_ctrl1", {14'd0, w_obs}, 32'd0);
        chk("midlw_rst_regwre1", {31'd0, RegWre}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midlw_after_state", {28'd0, state}, {28'd0, IF});

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 6'($urandom_range(0, 63));
                while (mnem.exists(op) || op == 6'b111111);
            end else begin
                op = def_ops[$urandom_range(0, def_ops.size() - 1)];
            end
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // HALT parks the FSM until reset.
        run_instr(6'b111111, 1'b0, 1'b0);
        halt_st = state;
        chk("halt_state_distinct", {31'd0, (halt_st > 4'd7)}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            opcode = 6'($urandom_range(0, 63));
            #1;
            chk($sformatf("halt_c%0d_state", c), {28'd0, state}, {28'd0, halt_st});
            chk($sformatf("halt_c%0d_ctrl", c), {14'd0, w_obs}, 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("halt_rst_state", {28'd0, state}, {28'd0, IF});
        run_instr(6'b010010, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
